// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO drain arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Width of an index or counter that must hold n distinct values, never below 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first asserted req found scanning from start upward, modulo NUM_SRC.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  // Walk the offsets from farthest to nearest so the nearest request is the last one written.
  always_comb begin
    int pos;
    any = 1'b0;
    idx = '0;
    pos = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      pos = (int'(start) + k) % NUM_SRC;
      if (req[pos]) begin
        any = 1'b1;
        idx = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain arbiter from NUM_SRC show-ahead FIFOs into one registered valid/ready stream.
// Define FIFO_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
//
// state     | meaning
// ARB_IDLE  | no grant held; pick next non-empty source, no pop
// ARB_BURST | grant held; pop grant source whenever output stage can load
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_empty,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_rd_data,
  output logic [NUM_SRC-1:0]            src_rd_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_SRC)-1:0]    out_src,
  output logic                          busy
);

  localparam int ARB_IDX_W = idx_width(NUM_SRC);
  localparam int CNT_W     = idx_width(MAX_BURST + 1);

`ifdef FIFO_ARB_STRICT_PRIO_EN
  localparam bit STRICT_PRIO = 1'b1;
`else
  localparam bit STRICT_PRIO = 1'b0;
`endif

  arb_state_t             state, state_nxt;
  logic [ARB_IDX_W-1:0]   grant, grant_nxt;
  logic [ARB_IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [ARB_IDX_W-1:0]   grant_inc, scan_start, pick_idx;
  logic [CNT_W-1:0]       burst_cnt, burst_cnt_nxt, cnt_inc;
  logic                   pick_any, load_ok, pop, grant_empty;
  logic [DATA_WIDTH-1:0]  src_word [NUM_SRC];

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_word[i] = src_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign scan_start  = STRICT_PRIO ? '0 : rr_ptr;
  assign grant_empty = src_empty[grant];
  assign grant_inc   = (grant == ARB_IDX_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
  assign cnt_inc     = burst_cnt + 1'b1;
  assign load_ok     = !out_valid || out_ready;
  assign pop         = (state == ARB_BURST) && load_ok && !grant_empty;
  assign busy        = (state == ARB_BURST);

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (ARB_IDX_W)
  ) u_rr_pick (
    .req   (~src_empty),
    .start (scan_start),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  always_comb begin
    src_rd_en = '0;
    if (pop) src_rd_en[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // A source that runs dry forfeits the rest of its burst; priority rotates past it either way.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_nxt     = ARB_BURST;
          grant_nxt     = pick_idx;
          burst_cnt_nxt = '0;
        end
      end
      ARB_BURST: begin
        if (pop) begin
          burst_cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_W'(MAX_BURST)) begin
            state_nxt  = ARB_IDLE;
            rr_ptr_nxt = STRICT_PRIO ? rr_ptr : grant_inc;
          end
        end else if (grant_empty) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = STRICT_PRIO ? rr_ptr : grant_inc;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= src_word[grant];
      out_src   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Randomized and directed bench for fifo_rr_arbiter against a queue-based behavioural model.
module tb_fifo_rr_arbiter;

  localparam int NUM_SRC    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

`ifdef FIFO_ARB_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_SRC-1:0]            src_empty;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_rd_data;
  logic [NUM_SRC-1:0]            src_rd_en;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [1:0]                    out_src;
  logic                          busy;

  fifo_rr_arbiter #(
    .NUM_SRC    (NUM_SRC),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_empty   (src_empty),
    .src_rd_data (src_rd_data),
    .src_rd_en   (src_rd_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_src     (out_src),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef logic [DATA_WIDTH-1:0] word_q_t [$];
  word_q_t fq [NUM_SRC];

  int n_checks = 0;
  int n_errors = 0;

  // Model: who holds the grant, how many words it has taken, where the next scan starts.
  bit m_busy, m_ov;
  int m_g, m_taken, m_ptr, m_od, m_os;

  int pop_log [$];
  int dlv_src [$];
  int dlv_data [$];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NUM_SRC; i++) begin
      src_empty[i] = (fq[i].size() == 0);
      src_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic push(input int s, input int d);
    fq[s].push_back(DATA_WIDTH'(d));
    refresh();
  endtask

  task automatic model_reset();
    m_busy = 0; m_ov = 0; m_g = 0; m_taken = 0; m_ptr = 0; m_od = 0; m_os = 0;
  endtask

  function automatic bit all_idle();
    bit r;
    r = !m_busy && !m_ov;
    for (int i = 0; i < NUM_SRC; i++) if (fq[i].size() != 0) r = 0;
    return r;
  endfunction

  task automatic end_burst();
    m_busy = 0;
    if (!STRICT) m_ptr = (m_g + 1) % NUM_SRC;
  endtask

  // Compare DUT against the model for this cycle, then advance the model across the next edge.
  task automatic model_eval();
    bit lok, pop;
    int exp_en, start, s;
    lok = !m_ov || out_ready;
    pop = m_busy && lok && (fq[m_g].size() > 0);
    exp_en = pop ? (1 << m_g) : 0;
    check_eq("busy", busy, m_busy);
    check_eq("src_rd_en", src_rd_en, exp_en);
    check_eq("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check_eq("out_data", out_data, m_od);
      check_eq("out_src", out_src, m_os);
    end
    if (m_busy) begin
      if (pop) begin
        m_od = fq[m_g][0];
        m_os = m_g;
        m_ov = 1;
        m_taken++;
        if (m_taken == MAX_BURST) end_burst();
      end else begin
        if (out_ready) m_ov = 0;
        if (fq[m_g].size() == 0) end_burst();
      end
    end else begin
      if (out_ready) m_ov = 0;
      start = STRICT ? 0 : m_ptr;
      for (int k = 0; k < NUM_SRC; k++) begin
        s = (start + k) % NUM_SRC;
        if (fq[s].size() > 0) begin
          m_busy = 1; m_g = s; m_taken = 0;
          break;
        end
      end
    end
  endtask

  task automatic step();
    logic [NUM_SRC-1:0] en;
    @(negedge clk);
    en = src_rd_en;
    if (out_valid && out_ready) begin
      dlv_src.push_back(out_src);
      dlv_data.push_back(out_data);
    end
    for (int i = 0; i < NUM_SRC; i++) if (en[i]) pop_log.push_back(i);
    model_eval();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_SRC; i++) if (en[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    refresh();
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int c = 0; c < 400 && !all_idle(); c++) step();
    check_eq(tag, all_idle(), 1);
  endtask

  task automatic clear_logs();
    pop_log.delete(); dlv_src.delete(); dlv_data.delete();
  endtask

  initial begin
    int exp_q [$];
    int nxt [NUM_SRC];
    int n_push, snap, data0;

    rst = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) fq[i].delete();
    refresh();
    model_reset();
    #2;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_src", out_src, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd_en", src_rd_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Burst limit: 6 words in every source.
    clear_logs();
    for (int s = 0; s < NUM_SRC; s++) for (int k = 0; k < 6; k++) push(s, s*16 + k);
    drain("drain_burst");
    exp_q.delete();
    if (STRICT) begin
      for (int s = 0; s < NUM_SRC; s++) for (int k = 0; k < 6; k++) exp_q.push_back(s);
    end else begin
      for (int s = 0; s < NUM_SRC; s++) for (int k = 0; k < 4; k++) exp_q.push_back(s);
      for (int s = 0; s < NUM_SRC; s++) for (int k = 0; k < 2; k++) exp_q.push_back(s);
    end
    check_eq("burst_pop_count", pop_log.size(), 24);
    for (int i = 0; i < 24 && i < pop_log.size(); i++) check_eq("burst_pop_order", pop_log[i], exp_q[i]);
    check_eq("burst_dlv_count", dlv_data.size(), 24);
    for (int s = 0; s < NUM_SRC; s++) nxt[s] = 0;
    for (int i = 0; i < dlv_data.size(); i++) begin
      check_eq("burst_dlv_word", dlv_data[i], dlv_src[i]*16 + nxt[dlv_src[i]]);
      nxt[dlv_src[i]]++;
    end

    // Single source with three words, then confirm rotation resumes after it.
    clear_logs();
    push(2, 'hA1); push(2, 'hA2); push(2, 'hA3);
    drain("drain_single");
    check_eq("single_dlv_count", dlv_data.size(), 3);
    for (int i = 0; i < 3 && i < dlv_data.size(); i++) begin
      check_eq("single_data", dlv_data[i], 'hA1 + i);
      check_eq("single_src", dlv_src[i], 2);
    end
    clear_logs();
    push(1, 'h11); push(3, 'h33);
    drain("drain_ptr3");
    check_eq("ptr_after_src2", (pop_log.size() > 0) ? pop_log[0] : -1, STRICT ? 1 : 3);

    // Early empty: two words in src1.
    clear_logs();
    push(1, 'h51); push(1, 'h52);
    drain("drain_early");
    check_eq("early_pop_count", pop_log.size(), 2);
    clear_logs();
    push(0, 'h01); push(2, 'h21);
    drain("drain_ptr2");
    check_eq("ptr_after_src1", (pop_log.size() > 0) ? pop_log[0] : -1, STRICT ? 0 : 2);

    // Backpressure for five cycles in the middle of a burst.
    clear_logs();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) push(1, 'h70 + k);
    for (int c = 0; c < 3; c++) step();
    check_eq("bp_pre_pops", pop_log.size(), 2);
    out_ready = 1'b0;
    snap = pop_log.size();
    data0 = out_data;
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("bp_hold_data", out_data, data0);
      check_eq("bp_hold_valid", out_valid, 1);
    end
    check_eq("bp_no_pop", pop_log.size(), snap);
    drain("drain_bp");
    check_eq("bp_dlv_count", dlv_data.size(), 6);
    for (int i = 0; i < 6 && i < dlv_data.size(); i++) check_eq("bp_dlv_word", dlv_data[i], 'h70 + i);

    // Asynchronous reset between edges during a src0 burst.
    clear_logs();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) push(0, 'h90 + k);
    for (int c = 0; c < 3; c++) step();
    push(3, 'hB0); push(3, 'hB1); push(3, 'hB2);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_rd_en", src_rd_en, 0);
    check_eq("arst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    clear_logs();
    for (int c = 0; c < 4; c++) step();
    check_eq("arst_first_grant", (pop_log.size() > 0) ? pop_log[0] : -1, 0);
    drain("drain_arst");

    // Random traffic and random backpressure.
    clear_logs();
    n_push = 0;
    for (int c = 0; c < 1500; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NUM_SRC; s++) begin
        if ($urandom_range(0, 5) == 0 && fq[s].size() < 8) begin
          push(s, $urandom_range(0, 255));
          n_push++;
        end
      end
      step();
    end
    drain("drain_random");
    check_eq("random_dlv_count", dlv_data.size(), n_push);

`ifdef FIFO_ARB_STRICT_PRIO_EN
    // src0 never runs dry, so src3 must never be granted.
    clear_logs();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin push(0, k); push(3, 'hC0 + k); end
    for (int c = 0; c < 60; c++) begin
      if (fq[0].size() < 3) push(0, c);
      step();
    end
    snap = 0;
    foreach (pop_log[i]) if (pop_log[i] == 3) snap++;
    check_eq("strict_src3_pops", snap, 0);
    for (int i = 0; i < NUM_SRC; i++) fq[i].delete();
    refresh();
    drain("drain_strict");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
